// File: rtl/multdiv_seq.sv
// Sequential signed multiply (radix-2 Booth) / divide (non-restoring) unit.
// A single WIDTH-bit lookahead adder is time-shared by every arithmetic step.

module multdiv_seq_cla8 (
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);
   logic [7:0] g, p;
   logic [8:0] c;
   logic       acc, prop;

   always_comb begin
      g    = x & y;
      p    = x ^ y;
      c    = '0;
      c[0] = cin;
      acc  = 1'b0;
      prop = 1'b0;
      // each carry is a flat OR of generate terms, not a ripple chain
      for (int i = 0; i < 8; i++) begin
         acc  = g[i];
         prop = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            acc  = acc | (prop & g[j]);
            prop = prop & p[j];
         end
         c[i+1] = acc | (prop & cin);
      end
      sum  = p ^ c[7:0];
      cout = c[8];
   end
endmodule

module multdiv_seq_adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int NB = WIDTH / 8;
   logic [NB:0] bc;

   assign bc[0] = cin;
   for (genvar i = 0; i < NB; i++) begin : g_blk
      multdiv_seq_cla8 u_cla (
         .x   (x[8*i +: 8]),
         .y   (y[8*i +: 8]),
         .cin (bc[i]),
         .sum (sum[8*i +: 8]),
         .cout(bc[i+1])
      );
   end
   assign cout = bc[NB];
endmodule

module multdiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
   state_t state, state_nxt;

   // hi is one bit wider than WIDTH so +/-(most negative) never overflows;
   // during divide hi holds the remainder R and lo the quotient Q.
   logic [WIDTH:0]   hi, nh;
   logic [WIDTH-1:0] lo, a;
   logic [CW-1:0]    cnt;
   logic             qm1, is_div, qneg, dz, ovf;

   logic [WIDTH-1:0] ax, ay, asum;
   logic             acin, acout, sub, xtop, top, start, last, mul_ovf;

   assign start = ctrl_MULT | ctrl_DIV;
   assign last  = (cnt == CW'(WIDTH-1));

   multdiv_seq_adder #(.WIDTH(WIDTH)) u_add (
      .x(ax), .y(ay), .cin(acin), .sum(asum), .cout(acout)
   );

   // The adder is free on a start cycle (any running op aborts), so it
   // forms |A| for a divide there; the divisor stays signed and the
   // add/sub choice folds in its sign instead.
   always_comb begin
      ax   = '0;
      ay   = '0;
      acin = 1'b0;
      sub  = 1'b0;
      xtop = 1'b0;
      if (start) begin
         ay   = data_operandA ^ {WIDTH{data_operandA[WIDTH-1]}};
         acin = data_operandA[WIDTH-1];
      end else begin
         case (state)
            MUL: begin
               sub  = lo[0] & ~qm1;
               ax   = hi[WIDTH-1:0];
               xtop = hi[WIDTH];
               ay   = a ^ {WIDTH{sub}};
               acin = sub;
            end
            DIV: begin
               sub  = ~hi[WIDTH] ^ a[WIDTH-1];
               ax   = {hi[WIDTH-2:0], lo[WIDTH-1]};
               xtop = hi[WIDTH-1];
               ay   = a ^ {WIDTH{sub}};
               acin = sub;
            end
            FIX: begin
               ay   = lo ^ {WIDTH{qneg}};
               acin = qneg;
            end
            default: ;
         endcase
      end
   end

   assign top     = xtop ^ a[WIDTH-1] ^ sub ^ acout;
   assign nh      = (lo[0] ^ qm1) ? {top, asum} : hi;
   assign mul_ovf = (hi[WIDTH-1:0] != {WIDTH{lo[WIDTH-1]}});

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = ctrl_MULT ? MUL : DIV;
      end else begin
         case (state)
            MUL:     if (last) state_nxt = DONE;
            DIV: begin
               if (dz)        state_nxt = DONE;
               else if (last) state_nxt = FIX;
            end
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hi             <= '0;
         lo             <= '0;
         a              <= '0;
         cnt            <= '0;
         qm1            <= 1'b0;
         is_div         <= 1'b0;
         qneg           <= 1'b0;
         dz             <= 1'b0;
         ovf            <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (state == DONE) begin
            data_resultRDY <= 1'b1;
            data_result    <= (is_div && dz) ? '0 : lo;
            data_exception <= is_div ? (dz | ovf) : mul_ovf;
         end
         if (start) begin
            cnt    <= '0;
            hi     <= '0;
            qm1    <= 1'b0;
            is_div <= ~ctrl_MULT;
            a      <= ctrl_MULT ? data_operandA : data_operandB;
            lo     <= ctrl_MULT ? data_operandB : asum;
            qneg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz     <= (data_operandB == '0);
            ovf    <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (data_operandB == '1);
         end else begin
            case (state)
               MUL: begin
                  cnt <= cnt + CW'(1);
                  hi  <= {nh[WIDTH], nh[WIDTH:1]};
                  lo  <= {nh[0], lo[WIDTH-1:1]};
                  qm1 <= lo[0];
               end
               DIV: if (!dz) begin
                  cnt <= cnt + CW'(1);
                  hi  <= {top, asum};
                  lo  <= {lo[WIDTH-2:0], ~top};
               end
               FIX:     lo <= asum;
               default: ;
            endcase
         end
      end
   end
endmodule
